mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STALL_W, default 6, is the width of the pipeline stall bus.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 stall  in  STALL_W  pipeline stall bus; bit 1 = IF/ID stage held.
REQ-005 inst_req  in  1  instruction-fetch read request.
REQ-006 inst_addr  in  32  fetch address.
REQ-007 inst_rdata  out  32  fetched instruction.
REQ-008 inst_valid  out  1  inst_rdata is valid this cycle.
REQ-009 data_req  in  1  load/store request.
REQ-010 data_wen  in  4  byte write enables; 4'b0000 = read.
REQ-011 data_addr  in  32  load/store address.
REQ-012 data_wdata  in  32  store data.
REQ-013 data_rdata  out  32  load data.
REQ-014 data_valid  out  1  data access completed this cycle.
REQ-015 sram_en, sram_wen[3:0], sram_addr[31:0], sram_wdata[31:0]  out  single-port SRAM command.
REQ-016 sram_rdata  in  32  SRAM read data, valid exactly 1 cycle after sram_en.
REQ-017 stallreq_arb  out  1  stall request to the pipeline controller.

Function
REQ-018 At most one SRAM access SHALL issue per cycle; back-to-back accesses every cycle SHALL be supported.
REQ-019 Grant is combinational; sources: pending fetch (P), data_req (D), inst_req (I).
REQ-020 Priority: P > D > I when P was deferred in the previous cycle; otherwise D > I. This guarantees no starvation.
REQ-021 If D and I are requested in the same cycle with no P, D SHALL be granted, inst_addr SHALL be latched into pend_addr, pend_v SHALL be set, and stallreq_arb SHALL be 1.
REQ-022 stallreq_arb SHALL stay at 1 while pend_v=1, and SHALL drop in the cycle P issues.
REQ-023 A granted access SHALL drive sram_en=1 with that requester's address; sram_wen/sram_wdata SHALL come from data_wen/data_wdata for D and be 0 for P and I.
REQ-024 No grant: sram_en=0 and sram_wen=0.
REQ-025 A 2-bit register resp_src SHALL record the granted source each cycle: NONE, INST or DATA.
REQ-026 resp_src=INST: inst_valid=1 and inst_rdata=sram_rdata, 1 cycle after grant.
REQ-027 resp_src=DATA: data_valid=1 1 cycle after grant; data_rdata=sram_rdata for a read and 0 for a write.
REQ-028 Hold buffer: at each edge with stall[1]=1, hold_en<=1 and hold_data<=current inst_rdata; at each edge with stall[1]=0, hold_en<=0.
REQ-029 While hold_en=1, inst_rdata SHALL be hold_data and inst_valid SHALL be 1.
REQ-030 A new fetch response arriving while hold_en=1 SHALL be discarded; the requester re-fetches.
REQ-031 inst_req with stall[1]=1 SHALL NOT be granted; data_req SHALL NOT be affected by stall.
REQ-032 Outputs not selected by resp_src/hold_en SHALL be 0.

Reset
REQ-033 When rst=1 at an edge, resp_src<=NONE, pend_v<=0, pend_addr<=0, hold_en<=0 and hold_data<=0.
REQ-034 While rst=1, all grants SHALL be suppressed: sram_en=0 and stallreq_arb=0.
REQ-035 Reset mid-operation SHALL discard any pending fetch and any in-flight response; the cycle after reset deasserts, inst_valid=0 and data_valid=0.

Verification
REQ-036 Fetch only: inst_req=1 at addr 0x100, SRAM returns 0x3C01_0001 -> next cycle inst_valid=1 and inst_rdata=0x3C01_0001; stallreq_arb=0.
REQ-037 Conflict: inst_req at 0x104 with data_req read at 0x2000 in the same cycle -> sram_addr=0x2000 and stallreq_arb=1; next cycle sram_addr=0x104 and data_valid=1; following cycle inst_valid=1 and stallreq_arb=0.
REQ-038 Store: data_wen=4'hF, addr 0x2004, wdata 0xDEADBEEF -> sram_wen=4'hF with the same addr/wdata; next cycle data_valid=1 and data_rdata=0.
REQ-039 Hold: fetch returns 0x0000_0021 and stall[1]=1 for 3 cycles -> inst_rdata stays 0x0000_0021 for all 3 cycles; hold_en clears 1 cycle after stall[1]=0.
REQ-040 Starvation: data_req held at 1 for 10 cycles with inst_req=1 -> fetch issues within 2 cycles, then grants alternate.
REQ-041 Reset with pend_v=1 -> after reset, no fetch issues at pend_addr and all outputs are 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port SRAM between instruction fetch and
// load/store traffic, with a one-deep deferred-fetch slot and an IF/ID
// hold buffer for the fetched instruction while the front end is stalled.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   stall[STALL_W-1:0]        pipeline stall bus (bit 1 = IF/ID held)
//   inst_req/inst_addr        fetch request
//   inst_rdata/inst_valid     fetch response (1 cycle after grant, or held)
//   data_req/wen/addr/wdata   load/store request (wen == 0 means read)
//   data_rdata/data_valid     load/store response (1 cycle after grant)
//   sram_en/wen/addr/wdata    SRAM command (combinational grant)
//   sram_rdata                SRAM read data, 1 cycle after sram_en
//   stallreq_arb              asserted in the cycle a fetch gets deferred
module mem_arbiter #(
    parameter int unsigned STALL_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               inst_req,
    input  logic [31:0]        inst_addr,
    output logic [31:0]        inst_rdata,
    output logic               inst_valid,
    input  logic               data_req,
    input  logic [3:0]         data_wen,
    input  logic [31:0]        data_addr,
    input  logic [31:0]        data_wdata,
    output logic [31:0]        data_rdata,
    output logic               data_valid,
    output logic               sram_en,
    output logic [3:0]         sram_wen,
    output logic [31:0]        sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata,
    output logic               stallreq_arb
);

    localparam int unsigned IF_STAGE = 1;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_INST = 2'd1,
        SRC_DATA = 2'd2
    } src_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PEND = 2'd1,
        GNT_DATA = 2'd2,
        GNT_INST = 2'd3
    } gnt_e;

    src_e        resp_src, resp_src_next;
    gnt_e        gnt;
    logic        resp_wr;
    logic        pend_v;
    logic [31:0] pend_addr;
    logic        hold_en;
    logic [31:0] hold_data;
    logic        set_pend;
    logic        if_stall;
    logic        stall_unused;

    assign if_stall     = stall[IF_STAGE];
    // Only the IF/ID bit of the stall bus matters here.
    assign stall_unused = ^stall;

    // Grant selection: a deferred fetch always wins the cycle after it lost.
    always_comb begin
        gnt           = GNT_NONE;
        set_pend      = 1'b0;
        resp_src_next = SRC_NONE;
        if (!rst) begin
            if (pend_v) begin
                gnt = GNT_PEND;
            end else if (data_req) begin
                gnt      = GNT_DATA;
                set_pend = inst_req && !if_stall;
            end else if (inst_req && !if_stall) begin
                gnt = GNT_INST;
            end
        end
        case (gnt)
            GNT_PEND, GNT_INST: resp_src_next = SRC_INST;
            GNT_DATA:           resp_src_next = SRC_DATA;
            default:            resp_src_next = SRC_NONE;
        endcase
    end

    // SRAM command driven straight from the grant.
    always_comb begin
        sram_en      = 1'b0;
        sram_wen     = 4'h0;
        sram_addr    = 32'h0;
        sram_wdata   = 32'h0;
        stallreq_arb = set_pend;
        case (gnt)
            GNT_PEND: begin
                sram_en   = 1'b1;
                sram_addr = pend_addr;
            end
            GNT_DATA: begin
                sram_en    = 1'b1;
                sram_wen   = data_wen;
                sram_addr  = data_addr;
                sram_wdata = data_wdata;
            end
            GNT_INST: begin
                sram_en   = 1'b1;
                sram_addr = inst_addr;
            end
            default: begin
                sram_en = 1'b0;
            end
        endcase
    end

    // Response source, deferred-fetch slot and IF/ID hold buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_src  <= SRC_NONE;
            resp_wr   <= 1'b0;
            pend_v    <= 1'b0;
            pend_addr <= 32'h0;
            hold_en   <= 1'b0;
            hold_data <= 32'h0;
        end else begin
            resp_src <= resp_src_next;
            resp_wr  <= (gnt == GNT_DATA) && (data_wen != 4'h0);
            pend_v   <= set_pend;
            if (set_pend) begin
                pend_addr <= inst_addr;
            end
            hold_en <= if_stall;
            if (if_stall) begin
                hold_data <= inst_rdata;
            end
        end
    end

    // Response steering; a fresh fetch response is dropped while holding.
    always_comb begin
        inst_valid = 1'b0;
        inst_rdata = 32'h0;
        data_valid = 1'b0;
        data_rdata = 32'h0;
        if (hold_en) begin
            inst_valid = 1'b1;
            inst_rdata = hold_data;
        end else if (resp_src == SRC_INST) begin
            inst_valid = 1'b1;
            inst_rdata = sram_rdata;
        end
        if (resp_src == SRC_DATA) begin
            data_valid = 1'b1;
            data_rdata = resp_wr ? 32'h0 : sram_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a behavioural
// model built on a sparse memory image and per-cycle transaction rules.
module tb_mem_arbiter;

    localparam int unsigned STALL_W = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               inst_req;
    logic [31:0]        inst_addr;
    logic [31:0]        inst_rdata;
    logic               inst_valid;
    logic               data_req;
    logic [3:0]         data_wen;
    logic [31:0]        data_addr;
    logic [31:0]        data_wdata;
    logic [31:0]        data_rdata;
    logic               data_valid;
    logic               sram_en;
    logic [3:0]         sram_wen;
    logic [31:0]        sram_addr;
    logic [31:0]        sram_wdata;
    logic [31:0]        sram_rdata;
    logic               stallreq_arb;

    mem_arbiter #(.STALL_W(STALL_W)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_rdata(inst_rdata), .inst_valid(inst_valid),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_valid(data_valid),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .stallreq_arb(stallreq_arb)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Sparse memory image; untouched words read back an address-derived pattern.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    // Model state: deferred fetch, what response is due now, hold buffer.
    bit          m_pend_v;
    logic [31:0] m_pend_addr;
    int          m_rsp;       // 0 none, 1 fetch response, 2 data response
    logic [31:0] m_rsp_data;
    bit          m_hold_en;
    logic [31:0] m_hold_data;

    // Outputs seen in the most recent cycle, for directed checks.
    logic [31:0] obs_sram_addr, obs_inst_rdata;
    logic        obs_sram_en, obs_inst_valid, obs_data_valid, obs_stallreq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step(input logic r, input logic [STALL_W-1:0] st,
                        input logic ir, input logic [31:0] ia,
                        input logic dr, input logic [3:0] dw,
                        input logic [31:0] da, input logic [31:0] dd);
        int          g;   // 0 none, 1 deferred fetch, 2 data, 3 fetch
        logic [31:0] g_addr, e_inst_rdata, rd, w;
        bit          conflict;
        rst = r; stall = st; inst_req = ir; inst_addr = ia;
        data_req = dr; data_wen = dw; data_addr = da; data_wdata = dd;
        #1;
        g = 0; g_addr = 32'h0; conflict = 0;
        if (!r) begin
            if (m_pend_v) begin g = 1; g_addr = m_pend_addr; end
            else if (dr) begin g = 2; g_addr = da; conflict = ir && !st[1]; end
            else if (ir && !st[1]) begin g = 3; g_addr = ia; end
        end
        e_inst_rdata = m_hold_en ? m_hold_data : (m_rsp == 1 ? m_rsp_data : 32'h0);
        check("sram_en",    {31'h0, sram_en},      {31'h0, g != 0});
        check("sram_addr",  sram_addr,             g_addr);
        check("sram_wen",   {28'h0, sram_wen},     {28'h0, (g == 2) ? dw : 4'h0});
        check("sram_wdata", sram_wdata,            (g == 2) ? dd : 32'h0);
        check("stallreq",   {31'h0, stallreq_arb}, {31'h0, conflict});
        check("inst_valid", {31'h0, inst_valid},   {31'h0, m_hold_en || m_rsp == 1});
        check("inst_rdata", inst_rdata,            e_inst_rdata);
        check("data_valid", {31'h0, data_valid},   {31'h0, m_rsp == 2});
        check("data_rdata", data_rdata,            (m_rsp == 2) ? m_rsp_data : 32'h0);
        obs_sram_en = sram_en; obs_sram_addr = sram_addr; obs_stallreq = stallreq_arb;
        obs_inst_valid = inst_valid; obs_inst_rdata = inst_rdata; obs_data_valid = data_valid;
        @(posedge clk);
        #1;
        rd = mem_rd(g_addr);
        if (r) begin
            m_pend_v = 0; m_pend_addr = 32'h0; m_rsp = 0; m_rsp_data = 32'h0;
            m_hold_en = 0; m_hold_data = 32'h0;
        end else begin
            if (g == 1 || g == 3) begin
                m_rsp = 1; m_rsp_data = rd;
            end else if (g == 2) begin
                m_rsp = 2; m_rsp_data = (dw != 4'h0) ? 32'h0 : rd;
                w = rd;
                for (int b = 0; b < 4; b++) if (dw[b]) w[8*b +: 8] = dd[8*b +: 8];
                if (dw != 4'h0) mem[da] = w;
            end else begin
                m_rsp = 0; m_rsp_data = 32'h0;
            end
            if (st[1]) begin m_hold_en = 1; m_hold_data = e_inst_rdata; end
            else m_hold_en = 0;
            m_pend_v = conflict;
            if (conflict) m_pend_addr = ia;
        end
        sram_rdata = (g != 0) ? rd : $urandom;
        @(negedge clk);
    endtask

    localparam logic [STALL_W-1:0] NO_ST = '0;
    localparam logic [STALL_W-1:0] IF_ST = STALL_W'(2);

    int fetch_cnt;

    initial begin
        rst = 1'b1; stall = '0; inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
        sram_rdata = '0;
        mem[32'h100] = 32'h3C01_0001;
        mem[32'h200] = 32'h0000_0021;
        m_pend_v = 0; m_pend_addr = '0; m_rsp = 0; m_rsp_data = '0;
        m_hold_en = 0; m_hold_data = '0;
        @(negedge clk); @(negedge clk);

        step(1, NO_ST, 0, 0, 0, 0, 0, 0);
        step(0, NO_ST, 0, 0, 0, 0, 0, 0);
        check("reset_inst_valid", {31'h0, obs_inst_valid}, 32'h0);

        // Fetch only.
        step(0, NO_ST, 1, 32'h100, 0, 0, 0, 0);
        check("fetch_stallreq", {31'h0, obs_stallreq}, 32'h0);
        step(0, NO_ST, 0, 0, 0, 0, 0, 0);
        check("fetch_rdata", obs_inst_rdata, 32'h3C01_0001);

        // Conflict: data wins, fetch replays next cycle.
        step(0, NO_ST, 1, 32'h104, 1, 4'h0, 32'h2000, 0);
        check("conf_addr0", obs_sram_addr, 32'h2000);
        check("conf_stall0", {31'h0, obs_stallreq}, 32'h1);
        step(0, NO_ST, 0, 0, 0, 0, 0, 0);
        check("conf_addr1", obs_sram_addr, 32'h104);
        check("conf_dvalid1", {31'h0, obs_data_valid}, 32'h1);
        step(0, NO_ST, 0, 0, 0, 0, 0, 0);
        check("conf_ivalid2", {31'h0, obs_inst_valid}, 32'h1);

        // Store, then read it back.
        step(0, NO_ST, 0, 0, 1, 4'hF, 32'h2004, 32'hDEAD_BEEF);
        step(0, NO_ST, 0, 0, 1, 4'h0, 32'h2004, 0);
        step(0, NO_ST, 0, 0, 0, 0, 0, 0);

        // Hold buffer across three stalled cycles.
        step(0, NO_ST, 1, 32'h200, 0, 0, 0, 0);
        step(0, IF_ST, 0, 0, 0, 0, 0, 0);
        step(0, IF_ST, 1, 32'h100, 0, 0, 0, 0);
        step(0, IF_ST, 0, 0, 0, 0, 0, 0);
        step(0, NO_ST, 0, 0, 0, 0, 0, 0);
        check("hold_rdata", obs_inst_rdata, 32'h0000_0021);
        step(0, NO_ST, 0, 0, 0, 0, 0, 0);
        check("hold_cleared", {31'h0, obs_inst_valid}, 32'h0);

        // Sustained data traffic must not starve fetch.
        fetch_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, NO_ST, 1, 32'h300, 1, 4'h0, 32'h3000 + 32'(i * 4), 0);
            if (obs_sram_addr == 32'h300) fetch_cnt++;
        end
        check("starve_fetches", 32'(fetch_cnt), 32'd5);
        step(0, NO_ST, 0, 0, 0, 0, 0, 0);

        // Reset while a fetch is deferred.
        step(0, NO_ST, 1, 32'h400, 1, 4'h0, 32'h2000, 0);
        step(1, NO_ST, 0, 0, 0, 0, 0, 0);
        step(0, NO_ST, 0, 0, 0, 0, 0, 0);
        check("rst_pend_en", {31'h0, obs_sram_en}, 32'h0);
        check("rst_pend_dvalid", {31'h0, obs_data_valid}, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [STALL_W-1:0] st;
            logic [3:0]         dw;
            st = STALL_W'($urandom);
            if ($urandom_range(0, 9) < 6) st[1] = 1'b0;
            dw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            step($urandom_range(0, 49) == 0, st,
                 1'($urandom), 32'h1000 + 32'($urandom_range(0, 15) * 4),
                 1'($urandom), dw, 32'h1000 + 32'($urandom_range(0, 15) * 4),
                 $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
